// File: rtl/rvvi_retire_collector.sv
// RVVI retirement collector: folds a token-level trace event stream into one record per RET/TRAP and queues records for the comparator.
// Optional RVVI_COLLECT_STATS_EN adds stat_ret/stat_trap counters of pushed records.
module rvvi_retire_collector #(
  parameter int XLEN  = 64,
  parameter int NHART = 4,
  parameter int DEPTH = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ev_valid,
  output logic                      ev_ready,
  input  logic [3:0]                ev_kind,
  input  logic [11:0]               ev_index,
  input  logic [XLEN-1:0]           ev_value,
  input  logic [31:0]               ev_insn,
  output logic                      rec_valid,
  input  logic                      rec_ready,
  output logic [XLEN-1:0]           rec_pc,
  output logic [31:0]               rec_insn,
  output logic                      rec_trap,
  output logic [XLEN-1:0]           rec_order,
  output logic [$clog2(NHART)-1:0]  rec_hart,
  output logic [7:0]                rec_issue,
  output logic                      rec_x_wb,
  output logic [4:0]                rec_x_idx,
  output logic [XLEN-1:0]           rec_x_data,
  output logic                      rec_f_wb,
  output logic [4:0]                rec_f_idx,
  output logic [XLEN-1:0]           rec_f_data,
  output logic [3:0]                rec_c_cnt,
  output logic [3:0]                err
`ifdef RVVI_COLLECT_STATS_EN
  ,
  output logic [31:0]               stat_ret,
  output logic [31:0]               stat_trap
`endif
);

  localparam int HW = $clog2(NHART);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]      DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [XLEN-1:0]  NHART_X = XLEN'(NHART);

  localparam logic [3:0] K_RET = 4'd0, K_TRAP = 4'd1, K_X = 4'd2, K_F = 4'd3, K_C = 4'd4,
                         K_HART = 4'd5, K_ORDER = 4'd6, K_ISSUE = 4'd7, K_EOL = 4'd8;

  typedef enum logic {IDLE, OPEN} state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     insn;
    logic            trap;
    logic [XLEN-1:0] order;
    logic [HW-1:0]   hart;
    logic [7:0]      issue;
    logic            x_wb;
    logic [4:0]      x_idx;
    logic [XLEN-1:0] x_data;
    logic            f_wb;
    logic [4:0]      f_idx;
    logic [XLEN-1:0] f_data;
    logic [3:0]      c_cnt;
  } rec_t;

  state_e          state_q;
  rec_t            open_q;
  logic [XLEN-1:0] order_q;
  logic [HW-1:0]   hart_q;
  logic [7:0]      issue_q;
  logic            autoinc_q;
  logic [3:0]      err_q;

  rec_t            mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [AW:0]     count_q;

  logic       needs_push, full, pop, push, accept;
  logic [7:0] issue_slot;
  rec_t       head;
  logic       unused_idx;

  assign unused_idx = ^ev_index[11:5];

  // Valid/ready: an event transfers on a cycle where ev_valid && ev_ready.
  // ev_ready drops only when the event must push into a full FIFO that is not popping this cycle.
  assign pop        = rec_valid && rec_ready;
  assign full       = (count_q == DEPTH_C);
  assign needs_push = (state_q == OPEN) &&
                      (ev_kind == K_RET || ev_kind == K_TRAP || ev_kind == K_EOL);
  assign ev_ready   = !(needs_push && full && !pop);
  assign accept     = ev_valid && ev_ready;
  assign push       = accept && needs_push;
  assign issue_slot = issue_q + {7'd0, autoinc_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      open_q    <= '0;
      order_q   <= '0;
      hart_q    <= '0;
      issue_q   <= '0;
      autoinc_q <= 1'b0;
      err_q     <= '0;
    end else if (accept) begin
      case (ev_kind)
        K_RET, K_TRAP: begin
          issue_q      <= issue_slot;
          autoinc_q    <= 1'b1;
          open_q       <= '0;
          open_q.pc    <= ev_value;
          open_q.insn  <= ev_insn;
          open_q.trap  <= (ev_kind == K_TRAP);
          open_q.order <= order_q;
          open_q.hart  <= hart_q;
          open_q.issue <= issue_slot;
          order_q      <= order_q + 1'b1;
          state_q      <= OPEN;
        end
        K_X: begin
          if (state_q == OPEN) begin
            if (open_q.x_wb) err_q[1] <= 1'b1;
            open_q.x_wb   <= 1'b1;
            open_q.x_idx  <= ev_index[4:0];
            open_q.x_data <= ev_value;
          end else begin
            err_q[3] <= 1'b1;
          end
        end
        K_F: begin
          if (state_q == OPEN) begin
            if (open_q.f_wb) err_q[1] <= 1'b1;
            open_q.f_wb   <= 1'b1;
            open_q.f_idx  <= ev_index[4:0];
            open_q.f_data <= ev_value;
          end else begin
            err_q[3] <= 1'b1;
          end
        end
        K_C: begin
          if (state_q == OPEN) begin
            if (open_q.c_cnt != 4'hF) open_q.c_cnt <= open_q.c_cnt + 4'd1;
          end else begin
            err_q[3] <= 1'b1;
          end
        end
        K_HART: begin
          if (ev_value >= NHART_X) begin
            err_q[2] <= 1'b1;
            hart_q   <= '0;
          end else begin
            hart_q   <= ev_value[HW-1:0];
          end
          issue_q   <= '0;
          autoinc_q <= 1'b0;
        end
        K_ORDER: begin
          if (ev_value < order_q) err_q[0] <= 1'b1;
          order_q <= ev_value;
        end
        K_ISSUE: begin
          issue_q   <= ev_value[7:0];
          autoinc_q <= 1'b0;
        end
        K_EOL: begin
          state_q   <= IDLE;
          issue_q   <= '0;
          autoinc_q <= 1'b0;
        end
        default: err_q[3] <= 1'b1;
      endcase
    end
  end

  // Storage needs no reset: the count gates every output.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= open_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign rec_valid  = (count_q != '0);
  assign head       = rec_valid ? mem_q[rd_ptr_q] : '0;
  assign rec_pc     = head.pc;
  assign rec_insn   = head.insn;
  assign rec_trap   = head.trap;
  assign rec_order  = head.order;
  assign rec_hart   = head.hart;
  assign rec_issue  = head.issue;
  assign rec_x_wb   = head.x_wb;
  assign rec_x_idx  = head.x_idx;
  assign rec_x_data = head.x_data;
  assign rec_f_wb   = head.f_wb;
  assign rec_f_idx  = head.f_idx;
  assign rec_f_data = head.f_data;
  assign rec_c_cnt  = head.c_cnt;
  assign err        = err_q;

`ifdef RVVI_COLLECT_STATS_EN
  logic [31:0] stat_ret_q, stat_trap_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_ret_q  <= '0;
      stat_trap_q <= '0;
    end else if (push) begin
      if (open_q.trap) begin
        if (stat_trap_q != 32'hFFFF_FFFF) stat_trap_q <= stat_trap_q + 32'd1;
      end else begin
        if (stat_ret_q != 32'hFFFF_FFFF) stat_ret_q <= stat_ret_q + 32'd1;
      end
    end
  end

  assign stat_ret  = stat_ret_q;
  assign stat_trap = stat_trap_q;
`endif

endmodule
